// File: rtl/circuit_pkg.sv
// Shared definitions for the circuit-drawing datapath.
// Holds the default geometry of the node-column table, the search FSM state
// encoding, the request-origin tag and the table entry layout.
package circuit_pkg;

  localparam int NODE_ID_W     = 5;   // node ID width
  localparam int X_W           = 9;   // x-coordinate width (320-pixel screen)
  localparam int MAX_NODES_DEF = 16;  // default number of table entries
  localparam int X_BASE_DEF    = 20;  // default x of entry 0
  localparam int X_STEP_DEF    = 18;  // default pitch between node columns

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SCAN,
    ST_DONE
  } state_t;

  // Which handshake started the current operation; DONE waits on that go only.
  typedef enum logic [1:0] {
    OP_CLEAR,
    OP_A,
    OP_B
  } op_t;

  typedef struct packed {
    logic                 valid;
    logic [NODE_ID_W-1:0] id;
    logic [X_W-1:0]       x;
  } node_entry_t;

endpackage

// File: rtl/node_table_regfile.sv
// Node-ID to x-column table.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (invalidates all)
//   wr_en/wr_idx/wr_id/wr_x   synchronous write of one valid entry
//   clr_en/clr_idx      synchronous invalidate of one entry
//   rd_idx/rd_entry     combinational read by index
module node_table_regfile
  import circuit_pkg::*;
#(
  parameter  int DEPTH = MAX_NODES_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_idx,
  input  logic [NODE_ID_W-1:0] wr_id,
  input  logic [X_W-1:0]       wr_x,
  input  logic                 clr_en,
  input  logic [AW-1:0]        clr_idx,
  input  logic [AW-1:0]        rd_idx,
  output node_entry_t          rd_entry
);

  logic [DEPTH-1:0]     valid_q;
  logic [NODE_ID_W-1:0] id_q [DEPTH];
  logic [X_W-1:0]       x_q  [DEPTH];

  // NOTE: only the valid bits are reset; the payload is meaningless while
  // valid is low, so it is left unreset and can map onto plain storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (wr_en)  valid_q[wr_idx]  <= 1'b1;
      if (clr_en) valid_q[clr_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      id_q[wr_idx] <= wr_id;
      x_q[wr_idx]  <= wr_x;
    end
  end

  always_comb begin
    rd_entry.valid = valid_q[rd_idx];
    rd_entry.id    = id_q[rd_idx];
    rd_entry.x     = x_q[rd_idx];
  end

endmodule

// File: rtl/node_search_unit.sv
// Node search unit: services clear / node-A / node-B lookups for the
// configure-circuit controller. A lookup scans the node table one entry per
// cycle; an unknown ID gets the next free column, x = X_BASE + n*X_STEP.
// Ports:
//   clk, program_resetn                   clock, asynchronous active-low reset
//   go_reset_data / data_reset_done       table clear handshake
//   go_search_node_A/B, node_A/B_id       lookup requests and IDs
//   node_A/B_found, node_A/B_x, node_A/B_new   lookup results
//   table_full_error                      sticky: allocation with a full table
//   node_count                            number of valid entries
module node_search_unit
  import circuit_pkg::*;
#(
  parameter  int MAX_NODES = MAX_NODES_DEF,
  parameter  int X_BASE    = X_BASE_DEF,
  parameter  int X_STEP    = X_STEP_DEF,
  localparam int CW        = $clog2(MAX_NODES) + 1,
  localparam int AW        = $clog2(MAX_NODES)
) (
  input  logic                 clk,
  input  logic                 program_resetn,
  input  logic                 go_reset_data,
  output logic                 data_reset_done,
  input  logic                 go_search_node_A,
  input  logic                 go_search_node_B,
  input  logic [NODE_ID_W-1:0] node_A_id,
  input  logic [NODE_ID_W-1:0] node_B_id,
  output logic                 node_A_found,
  output logic                 node_B_found,
  output logic [X_W-1:0]       node_A_x,
  output logic [X_W-1:0]       node_B_x,
  output logic                 node_A_new,
  output logic                 node_B_new,
  output logic                 table_full_error,
  output logic [CW-1:0]        node_count
);

  state_t               state_q, state_n;
  op_t                  op_q, op_n;
  logic [CW-1:0]        idx_q, idx_n;
  logic [CW-1:0]        count_q, count_n;
  logic [NODE_ID_W-1:0] id_q, id_n;
  logic                 err_q, err_n;
  logic                 done_q, done_n;
  logic                 a_found_q, a_found_n, b_found_q, b_found_n;
  logic [X_W-1:0]       a_x_q, a_x_n, b_x_q, b_x_n;
  logic                 a_new_q, a_new_n, b_new_q, b_new_n;

  logic                 wr_en, clr_en, go_active;
  logic                 res_valid, res_new;
  logic [X_W-1:0]       res_x, alloc_x;
  node_entry_t          rd_entry;

  node_table_regfile #(.DEPTH(MAX_NODES)) u_table (
    .clk      (clk),
    .rst_n    (program_resetn),
    .wr_en    (wr_en),
    .wr_idx   (count_q[AW-1:0]),
    .wr_id    (id_q),
    .wr_x     (alloc_x),
    .clr_en   (clr_en),
    .clr_idx  (idx_q[AW-1:0]),
    .rd_idx   (idx_q[AW-1:0]),
    .rd_entry (rd_entry)
  );

  // Column of the next allocation, evaluated at X_W width.
  assign alloc_x = X_W'(X_BASE) + X_W'(count_q) * X_W'(X_STEP);

  // The go that launched the current operation; DONE is released when it drops.
  always_comb begin
    go_active = 1'b0;
    case (op_q)
      OP_CLEAR: go_active = go_reset_data;
      OP_A:     go_active = go_search_node_A;
      OP_B:     go_active = go_search_node_B;
      default:  go_active = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_n   = state_q;
    op_n      = op_q;
    idx_n     = idx_q;
    id_n      = id_q;
    count_n   = count_q;
    err_n     = err_q;
    done_n    = done_q;
    a_found_n = a_found_q;
    b_found_n = b_found_q;
    a_x_n     = a_x_q;
    b_x_n     = b_x_q;
    a_new_n   = a_new_q;
    b_new_n   = b_new_q;
    wr_en     = 1'b0;
    clr_en    = 1'b0;
    res_valid = 1'b0;
    res_x     = '0;
    res_new   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (go_reset_data) begin
          state_n = ST_CLEAR;
          op_n    = OP_CLEAR;
          idx_n   = '0;
        end else if (go_search_node_A) begin
          state_n = ST_SCAN;
          op_n    = OP_A;
          id_n    = node_A_id;
          idx_n   = '0;
        end else if (go_search_node_B) begin
          state_n = ST_SCAN;
          op_n    = OP_B;
          id_n    = node_B_id;
          idx_n   = '0;
        end
      end

      ST_CLEAR: begin
        clr_en = 1'b1;
        if (idx_q == CW'(MAX_NODES - 1)) begin
          count_n = '0;
          err_n   = 1'b0;
          done_n  = 1'b1;
          state_n = ST_DONE;
        end else begin
          idx_n = idx_q + CW'(1);
        end
      end

      ST_SCAN: begin
        if (go_reset_data) begin
          // A clear request overrides the search: nothing is written.
          state_n = ST_CLEAR;
          op_n    = OP_CLEAR;
          idx_n   = '0;
        end else if (idx_q < count_q) begin
          if (rd_entry.valid && (rd_entry.id == id_q)) begin
            res_valid = 1'b1;
            res_x     = rd_entry.x;
          end else begin
            idx_n = idx_q + CW'(1);
          end
        end else if (count_q < CW'(MAX_NODES)) begin
          wr_en     = 1'b1;
          count_n   = count_q + CW'(1);
          res_valid = 1'b1;
          res_x     = alloc_x;
          res_new   = 1'b1;
        end else begin
          // Full table: flag it but still complete so the controller moves on.
          err_n     = 1'b1;
          res_valid = 1'b1;
        end
      end

      ST_DONE: begin
        if (!go_active) begin
          state_n   = ST_IDLE;
          done_n    = 1'b0;
          a_found_n = 1'b0;
          b_found_n = 1'b0;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    if (res_valid) begin
      state_n = ST_DONE;
      if (op_q == OP_B) begin
        b_found_n = 1'b1;
        b_x_n     = res_x;
        b_new_n   = res_new;
      end else begin
        a_found_n = 1'b1;
        a_x_n     = res_x;
        a_new_n   = res_new;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge program_resetn) begin
    if (!program_resetn) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_CLEAR;
      idx_q     <= '0;
      count_q   <= '0;
      id_q      <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      a_found_q <= 1'b0;
      b_found_q <= 1'b0;
      a_x_q     <= '0;
      b_x_q     <= '0;
      a_new_q   <= 1'b0;
      b_new_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      op_q      <= op_n;
      idx_q     <= idx_n;
      count_q   <= count_n;
      id_q      <= id_n;
      err_q     <= err_n;
      done_q    <= done_n;
      a_found_q <= a_found_n;
      b_found_q <= b_found_n;
      a_x_q     <= a_x_n;
      b_x_q     <= b_x_n;
      a_new_q   <= a_new_n;
      b_new_q   <= b_new_n;
    end
  end

  assign data_reset_done  = done_q;
  assign node_A_found     = a_found_q;
  assign node_B_found     = b_found_q;
  assign node_A_x         = a_x_q;
  assign node_B_x         = b_x_q;
  assign node_A_new       = a_new_q;
  assign node_B_new       = b_new_q;
  assign table_full_error = err_q;
  assign node_count       = count_q;

endmodule

// File: tb/tb_node_search_unit.sv
// Scoreboard bench for node_search_unit. The driver issues requests and pushes
// the response predicted by a list-based model of the node table; a monitor
// pops and compares whenever found / data_reset_done rises.
// Timing convention: "accept" is the rising edge on which IDLE takes the go.
// A search resolving entry k raises found on edge accept+1+k (a controller
// sampling on rising edges therefore sees it at cycle 2+k); a clear raises
// data_reset_done on edge accept+MAX_NODES.
module tb_node_search_unit;
  import circuit_pkg::*;

  localparam int MAXN  = MAX_NODES_DEF;
  localparam int EV_A  = 0;
  localparam int EV_B  = 1;
  localparam int EV_CL = 2;

  typedef struct {
    int kind;
    int x;
    int is_new;
    int count;
    int err;
    int rise;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 program_resetn;
  logic                 go_reset_data, go_search_node_A, go_search_node_B;
  logic [NODE_ID_W-1:0] node_A_id, node_B_id;
  logic                 data_reset_done, node_A_found, node_B_found;
  logic [X_W-1:0]       node_A_x, node_B_x;
  logic                 node_A_new, node_B_new, table_full_error;
  logic [$clog2(MAXN):0] node_count;

  node_search_unit dut (
    .clk              (clk),
    .program_resetn   (program_resetn),
    .go_reset_data    (go_reset_data),
    .data_reset_done  (data_reset_done),
    .go_search_node_A (go_search_node_A),
    .go_search_node_B (go_search_node_B),
    .node_A_id        (node_A_id),
    .node_B_id        (node_B_id),
    .node_A_found     (node_A_found),
    .node_B_found     (node_B_found),
    .node_A_x         (node_A_x),
    .node_B_x         (node_B_x),
    .node_A_new       (node_A_new),
    .node_B_new       (node_B_new),
    .table_full_error (table_full_error),
    .node_count       (node_count)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   total = 0;
  int   bad = 0;
  int   events_seen = 0;
  exp_t sb[$];

  // Reference model: IDs in allocation order; position gives the column.
  int   m_ids[$];
  int   m_err = 0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_search(input int side, input int id, input int accept, output exp_t e);
    int k = -1;
    foreach (m_ids[i]) if (m_ids[i] == id) k = i;
    e.kind = side ? EV_B : EV_A;
    if (k >= 0) begin
      e.x = X_BASE_DEF + k * X_STEP_DEF;
      e.is_new = 0;
      e.rise = accept + 1 + k;
    end else if (m_ids.size() < MAXN) begin
      e.x = X_BASE_DEF + m_ids.size() * X_STEP_DEF;
      e.is_new = 1;
      e.rise = accept + 1 + m_ids.size();
      m_ids.push_back(id);
    end else begin
      e.x = 0;
      e.is_new = 0;
      e.rise = accept + 1 + MAXN;
      m_err = 1;
    end
    e.count = m_ids.size();
    e.err = m_err;
  endtask

  task automatic model_clear(input int accept, output exp_t e);
    m_ids.delete();
    m_err = 0;
    e.kind = EV_CL; e.x = 0; e.is_new = 0; e.count = 0; e.err = 0;
    e.rise = accept + MAXN;
  endtask

  // Monitor: fires on any rising result strobe.
  bit prev_a = 0, prev_b = 0, prev_d = 0;
  always @(negedge clk) begin
    int ev;
    exp_t e;
    ev = -1;
    if (node_A_found && !prev_a)         ev = EV_A;
    else if (node_B_found && !prev_b)    ev = EV_B;
    else if (data_reset_done && !prev_d) ev = EV_CL;
    prev_a = node_A_found;
    prev_b = node_B_found;
    prev_d = data_reset_done;
    if (ev >= 0) begin
      events_seen++;
      if (sb.size() == 0) begin
        check("unexpected_output", ev, -1);
      end else begin
        e = sb.pop_front();
        check("event_kind", ev, e.kind);
        check("rise_edge", cyc, e.rise);
        if (ev == EV_A) begin
          check("a_x", int'(node_A_x), e.x);
          check("a_new", int'(node_A_new), e.is_new);
        end else if (ev == EV_B) begin
          check("b_x", int'(node_B_x), e.x);
          check("b_new", int'(node_B_new), e.is_new);
        end
        check("node_count", int'(node_count), e.count);
        check("table_full_error", int'(table_full_error), e.err);
      end
    end
  end

  task automatic wait_event(input int seen0, input string what);
    int n = 0;
    while (events_seen == seen0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (events_seen == seen0) check({what, "_timeout"}, 0, 1);
  endtask

  task automatic drop_go(input int side);
    if (side != 0) go_search_node_B = 1'b0;
    else           go_search_node_A = 1'b0;
  endtask

  task automatic run_search(input int side, input int id, input bit drop_early, input int hold);
    exp_t e;
    int   seen0;
    @(negedge clk);
    if (side != 0) begin node_B_id = NODE_ID_W'(id); go_search_node_B = 1'b1; end
    else           begin node_A_id = NODE_ID_W'(id); go_search_node_A = 1'b1; end
    model_search(side, id, cyc + 1, e);
    sb.push_back(e);
    seen0 = events_seen;
    @(negedge clk);
    // The ID is latched at acceptance; later changes must not matter.
    node_A_id = NODE_ID_W'($urandom);
    node_B_id = NODE_ID_W'($urandom);
    if (drop_early) drop_go(side);
    wait_event(seen0, "search");
    if (!drop_early) begin
      repeat (hold) @(negedge clk);
      @(negedge clk);
      drop_go(side);
    end
  endtask

  task automatic run_clear(input int hold);
    exp_t e;
    int   seen0;
    @(negedge clk);
    go_reset_data = 1'b1;
    model_clear(cyc + 1, e);
    sb.push_back(e);
    seen0 = events_seen;
    wait_event(seen0, "clear");
    repeat (hold) @(negedge clk);
    @(negedge clk);
    go_reset_data = 1'b0;
  endtask

  function automatic int fresh_id();
    int id;
    bit used;
    do begin
      id = $urandom_range(0, 31);
      used = 0;
      foreach (m_ids[i]) if (m_ids[i] == id) used = 1;
    end while (used);
    return id;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   seen0, acc, id_a, id_b;

    program_resetn = 1'b0;
    go_reset_data = 1'b0; go_search_node_A = 1'b0; go_search_node_B = 1'b0;
    node_A_id = '0; node_B_id = '0;
    #3;
    check("rst_found_a", int'(node_A_found), 0);
    check("rst_found_b", int'(node_B_found), 0);
    check("rst_done", int'(data_reset_done), 0);
    check("rst_count", int'(node_count), 0);
    check("rst_err", int'(table_full_error), 0);
    check("rst_a_x", int'(node_A_x), 0);
    @(negedge clk);
    program_resetn = 1'b1;

    // Plan 1 and 2: allocate 7 (A), allocate 3 (B), rediscover 7 (A).
    run_search(0, 7, 1'b0, 1);
    run_search(1, 3, 1'b0, 0);
    run_search(0, 7, 1'b0, 2);

    // Plan 3: fill the table, overflow with a new ID, then clear.
    while (m_ids.size() < MAXN) run_search($urandom_range(0, 1), fresh_id(), 1'b0, 0);
    run_search(0, m_ids[$urandom_range(0, MAXN - 1)], 1'b0, 0);
    run_search(0, fresh_id(), 1'b0, 1);
    check("full_flag_held", int'(table_full_error), 1);
    run_clear(2);

    // Plan 4: A and B together; B waits until A's go drops.
    run_search(0, 9, 1'b0, 0);
    id_a = 12; id_b = 9;
    @(negedge clk);
    node_A_id = NODE_ID_W'(id_a); node_B_id = NODE_ID_W'(id_b);
    go_search_node_A = 1'b1; go_search_node_B = 1'b1;
    model_search(0, id_a, cyc + 1, e);
    sb.push_back(e);
    seen0 = events_seen;
    wait_event(seen0, "both_a");
    repeat (3) begin
      @(negedge clk);
      check("b_waits_for_a", int'(node_B_found), 0);
    end
    @(negedge clk);
    go_search_node_A = 1'b0;
    acc = cyc + 2;  // next edge leaves DONE, the one after accepts B
    model_search(1, id_b, acc, e);
    sb.push_back(e);
    seen0 = events_seen;
    wait_event(seen0, "both_b");
    @(negedge clk);
    go_search_node_B = 1'b0;

    // Plan 5: clear request arriving mid-scan aborts the search.
    run_search(1, 21, 1'b0, 0);
    @(negedge clk);
    node_A_id = NODE_ID_W'(fresh_id());
    go_search_node_A = 1'b1;
    @(negedge clk);
    go_reset_data = 1'b1;
    go_search_node_A = 1'b0;
    acc = m_ids.size();
    model_clear(cyc + 1, e);
    sb.push_back(e);
    seen0 = events_seen;
    @(negedge clk);
    check("abort_no_write", int'(node_count), acc);
    check("abort_no_found", int'(node_A_found), 0);
    wait_event(seen0, "abort_clear");
    @(negedge clk);
    go_reset_data = 1'b0;

    // Plan 6: asynchronous reset while sitting in DONE.
    run_search(1, 4, 1'b0, 0);
    @(negedge clk);
    node_A_id = 5'd17;
    go_search_node_A = 1'b1;
    model_search(0, 17, cyc + 1, e);
    sb.push_back(e);
    seen0 = events_seen;
    wait_event(seen0, "pre_reset");
    check("pre_reset_found", int'(node_A_found), 1);
    #2 program_resetn = 1'b0;
    #1;
    check("async_found_a", int'(node_A_found), 0);
    check("async_a_x", int'(node_A_x), 0);
    check("async_b_x", int'(node_B_x), 0);
    check("async_a_new", int'(node_A_new), 0);
    check("async_count", int'(node_count), 0);
    check("async_err", int'(table_full_error), 0);
    go_search_node_A = 1'b0;
    m_ids.delete();
    m_err = 0;
    @(negedge clk);
    program_resetn = 1'b1;

    // Randomized traffic over a small ID space so matches and overflow occur.
    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 8) run_clear($urandom_range(0, 2));
      else run_search($urandom_range(0, 1), $urandom_range(0, 19), (r < 25), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
